// File: rtl/interrupt_controller.sv
// Edge-detecting, maskable, fixed-priority interrupt controller with a request/ack/done handshake.
// Optional macro INTC_SYNC_EN adds a 2-flop synchronizer on each hardware line before edge detect.
module interrupt_controller #(
    parameter logic [15:0] VECTOR_BASE   = 16'h0100,
    parameter logic [15:0] VECTOR_STRIDE = 16'h0010
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  hardware,
    input  logic [15:0] PC,
    input  logic        int_ack,
    input  logic        int_done,
    input  logic        mask_we,
    input  logic [7:0]  mask_data,
    output logic        int_req,
    output logic [15:0] int_vector,
    output logic [2:0]  int_code,
    output logic [15:0] interrupt_reg,
    output logic [7:0]  pending,
    output logic        in_service
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  hw_q, edge_src, rise;
    logic [7:0]  pending_q, pending_d, mask_q, active, clr;
    logic [2:0]  code_q, code_d, sel;
    logic [15:0] ireg_q, ireg_d;
    logic        any;

`ifdef INTC_SYNC_EN
    logic [7:0] sync1_q, sync2_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= hardware;
            sync2_q <= sync1_q;
        end
    end

    assign edge_src = sync2_q;
`else
    assign edge_src = hardware;
`endif

    // Lowest-index unmasked pending line wins.
    always_comb begin
        rise   = edge_src & ~hw_q;
        active = pending_q & mask_q;
        any    = |active;
        sel    = '0;
        for (int i = 7; i >= 0; i--) begin
            if (active[i]) sel = 3'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        ireg_d  = ireg_q;
        clr     = '0;
        case (state_q)
            IDLE: begin
                if (any) begin
                    state_d = REQ;
                    code_d  = sel;
                end
            end
            REQ: begin
                if (!any) begin
                    state_d = IDLE;
                end else begin
                    code_d = sel;
                    if (int_ack) begin
                        state_d = SERVICE;
                        ireg_d  = PC;
                        clr     = 8'd1 << sel;
                    end
                end
            end
            SERVICE: begin
                if (int_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Clearing the acknowledged line wins over a same-edge new event on it.
        pending_d = (pending_q | rise) & ~clr;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            hw_q      <= '0;
            pending_q <= '0;
            mask_q    <= 8'hFF;
            code_q    <= '0;
            ireg_q    <= '0;
        end else begin
            state_q   <= state_d;
            hw_q      <= edge_src;
            pending_q <= pending_d;
            code_q    <= code_d;
            ireg_q    <= ireg_d;
            if (mask_we) mask_q <= mask_data;
        end
    end

    // While requesting, the choice tracks live so a higher-priority arrival preempts it.
    assign int_code      = (state_q == REQ && any) ? sel : code_q;
    assign int_vector    = VECTOR_BASE + VECTOR_STRIDE * {13'd0, int_code};
    assign int_req       = (state_q == REQ);
    assign in_service    = (state_q == SERVICE);
    assign interrupt_reg = ireg_q;
    assign pending       = pending_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed and randomized bench for interrupt_controller against a behavioural reference model.
module tb_interrupt_controller;

    localparam logic [15:0] BASE   = 16'h0100;
    localparam logic [15:0] STRIDE = 16'h0010;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [7:0]  hardware;
    logic [15:0] PC;
    logic        int_ack, int_done, mask_we;
    logic [7:0]  mask_data;
    logic        int_req, in_service;
    logic [15:0] int_vector, interrupt_reg;
    logic [2:0]  int_code;
    logic [7:0]  pending;

    int passed = 0;
    int total  = 0;

    // Reference model: mode 0 = idle, 1 = requesting, 2 = handler running.
    logic [7:0]  m_pend, m_prev, m_mask;
    int          m_mode, m_code;
    logic [15:0] m_ireg;

    interrupt_controller dut (
        .CLK(CLK), .RST_N(RST_N), .hardware(hardware), .PC(PC),
        .int_ack(int_ack), .int_done(int_done), .mask_we(mask_we), .mask_data(mask_data),
        .int_req(int_req), .int_vector(int_vector), .int_code(int_code),
        .interrupt_reg(interrupt_reg), .pending(pending), .in_service(in_service)
    );

    always #5 CLK = ~CLK;

    function automatic int lowest(input logic [7:0] v);
        int  r = 0;
        bit  found = 0;
        for (int i = 0; i < 8; i++) begin
            if (v[i] && !found) begin
                r = i;
                found = 1;
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pend = '0; m_prev = '0; m_mask = 8'hFF;
        m_mode = 0;  m_code = 0;  m_ireg = '0;
    endtask

    task automatic model_step();
        logic [7:0] rise, act, clr;
        int sel;
        if (!RST_N) begin
            model_reset();
        end else begin
            rise = hardware & ~m_prev;
            act  = m_pend & m_mask;
            sel  = lowest(act);
            clr  = '0;
            if (m_mode == 0) begin
                if (act != 0) begin m_mode = 1; m_code = sel; end
            end else if (m_mode == 1) begin
                if (act == 0) m_mode = 0;
                else begin
                    m_code = sel;
                    if (int_ack) begin m_mode = 2; m_ireg = PC; clr[sel] = 1'b1; end
                end
            end else if (int_done) begin
                m_mode = 0;
            end
            m_pend = (m_pend | rise) & ~clr;
            m_prev = hardware;
            if (mask_we) m_mask = mask_data;
        end
    endtask

    task automatic compare_all(input string ctx);
        int          ecode;
        logic [15:0] evec;
        ecode = (m_mode == 1 && (m_pend & m_mask) != 0) ? lowest(m_pend & m_mask) : m_code;
        evec  = 16'(BASE + ecode * STRIDE);
        check({ctx, "/int_req"},    int_req,       (m_mode == 1));
        check({ctx, "/in_service"}, in_service,    (m_mode == 2));
        check({ctx, "/int_code"},   int_code,      16'(ecode));
        check({ctx, "/int_vector"}, int_vector,    evec);
        check({ctx, "/irq_reg"},    interrupt_reg, m_ireg);
        check({ctx, "/pending"},    pending,       m_pend);
    endtask

    task automatic tick(input string ctx);
        @(posedge CLK);
        model_step();
        #1;
        compare_all(ctx);
    endtask

    initial begin
        RST_N = 1'b0; hardware = '0; PC = '0; int_ack = 0; int_done = 0;
        mask_we = 0; mask_data = '0;
        model_reset();
        #12;
        compare_all("reset");
        check("reset_vec", int_vector, 16'h0100);
        tick("reset_hold");
        RST_N = 1'b1;

        // Single event
        hardware = 8'h02; PC = 16'h0042;
        tick("single_edge");
        check("single_pend", pending, 16'h0002);
        hardware = 8'h00;
        tick("single_req");
        check("single_int_req", int_req, 1);
        check("single_code", int_code, 1);
        check("single_vec", int_vector, 16'h0110);
        int_ack = 1; tick("single_ack"); int_ack = 0;
        check("single_ireg", interrupt_reg, 16'h0042);
        check("single_pend_clr", pending, 16'h0000);
        check("single_insvc", in_service, 1);
        int_done = 1; tick("single_done"); int_done = 0;
        check("single_idle", in_service, 0);

        // Priority preemption
        hardware = 8'h10; tick("prio_l4");
        hardware = 8'h00; tick("prio_req4");
        check("prio_code4", int_code, 4);
        hardware = 8'h02; tick("prio_l1");
        hardware = 8'h00;
        check("prio_code1", int_code, 1);
        PC = 16'h0300;
        int_ack = 1; tick("prio_ack1"); int_ack = 0;
        check("prio_pend4", pending, 16'h0010);
        int_done = 1; tick("prio_done1"); int_done = 0;
        check("prio_gap", int_req, 0);
        tick("prio_req4b");
        check("prio_req4b", int_req, 1);
        check("prio_vec4", int_vector, 16'h0140);
        int_ack = 1; tick("prio_ack4"); int_ack = 0;
        int_done = 1; tick("prio_done4"); int_done = 0;

        // Mask
        mask_we = 1; mask_data = 8'hEF; tick("mask_wr"); mask_we = 0;
        hardware = 8'h10; tick("mask_ev");
        hardware = 8'h00; tick("mask_w1"); tick("mask_w2");
        check("mask_pend", pending, 16'h0010);
        check("mask_noreq", int_req, 0);
        mask_we = 1; mask_data = 8'hFF; tick("mask_en"); mask_we = 0;
        check("mask_en_noreq", int_req, 0);
        tick("mask_req");
        check("mask_req", int_req, 1);
        check("mask_code", int_code, 4);
        int_ack = 1; tick("mask_ack"); int_ack = 0;
        int_done = 1; tick("mask_done"); int_done = 0;

        // Held pulse and re-arm
        hardware = 8'h02;
        repeat (20) tick("held");
        hardware = 8'h00;
        check("held_pend", pending, 16'h0002);
        PC = 16'h0500;
        int_ack = 1; tick("held_ack"); int_ack = 0;
        check("held_once", pending, 16'h0000);
        hardware = 8'h02; tick("rearm_ev"); hardware = 8'h00;
        check("rearm_pend", pending, 16'h0002);
        check("rearm_insvc", in_service, 1);
        int_done = 1; tick("rearm_done"); int_done = 0;
        tick("rearm_req");
        check("rearm_req", int_req, 1);
        check("rearm_code", int_code, 1);
        int_ack = 1; tick("rearm_ack"); int_ack = 0;
        int_done = 1; tick("rearm_done2"); int_done = 0;

        // Stray handshake
        PC = 16'hBEEF;
        int_ack = 1; tick("stray_ack"); int_ack = 0;
        check("stray_ack_req", int_req, 0);
        check("stray_ack_svc", in_service, 0);
        check("stray_ack_ireg", interrupt_reg, 16'h0500);
        hardware = 8'h08; tick("stray_ev");
        hardware = 8'h00; tick("stray_req");
        int_done = 1; tick("stray_done"); int_done = 0;
        check("stray_done_req", int_req, 1);
        check("stray_done_ireg", interrupt_reg, 16'h0500);
        int_ack = 1; tick("stray_ack2"); int_ack = 0;
        int_done = 1; tick("stray_done2"); int_done = 0;

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) hardware = 8'($urandom);
            else if ($urandom_range(0, 1) == 0) hardware = '0;
            PC        = 16'($urandom);
            int_ack   = ($urandom_range(0, 2) == 0);
            int_done  = ($urandom_range(0, 3) == 0);
            mask_we   = ($urandom_range(0, 15) == 0);
            mask_data = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            tick("rand");
        end
        hardware = '0; int_ack = 0; int_done = 0;

        // Reset mid-service
        mask_we = 1; mask_data = 8'hFF; tick("pre_mask"); mask_we = 0;
        int_done = 1; tick("pre_done"); int_done = 0;
        hardware = 8'h01; tick("pre_ev");
        hardware = 8'h00; tick("pre_req");
        int_ack = 1; tick("pre_ack"); int_ack = 0;
        check("pre_insvc", in_service, 1);
        #2;
        RST_N = 1'b0;
        #1;
        model_reset();
        compare_all("rst_async");
        check("rst_insvc", in_service, 0);
        check("rst_ireg", interrupt_reg, 16'h0000);
        check("rst_vec", int_vector, 16'h0100);
        tick("rst_hold");
        RST_N = 1'b1;
        hardware = 8'h80; tick("post_ev");
        hardware = 8'h00; tick("post_req");
        check("post_mask_ff", int_req, 1);
        check("post_vec7", int_vector, 16'h0170);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Sequences external-event interrupts into the 16-bit multicycle processor. It edge-detects the 8 `hardware` button/event lines and latches them as pending. It selects the highest-priority unmasked pending event and handshakes with the control FSM (request, acknowledge, done). On acknowledge it captures the return PC into `interrupt_reg` and supplies the handler vector that the control FSM loads into the PC mux.

## Interface

Parameters:
- `VECTOR_BASE`, default 16'h0100: address of the handler for line 0.
- `VECTOR_STRIDE`, default 16'h0010: address spacing between consecutive handlers.

Ports:
- `CLK`, input, 1: the only clock; all state changes on the rising edge.
- `RST_N`, input, 1: reset, asynchronous and active-low.
- `hardware`, input, 8: raw event lines, level-high while active, any pulse length of 1 or more cycles.
- `PC`, input, 16: current program counter, sampled on acknowledge.
- `int_ack`, input, 1: control FSM has entered its interrupt-entry state.
- `int_done`, input, 1: return-from-interrupt has executed.
- `mask_we`, input, 1: write enable for the mask register.
- `mask_data`, input, 8: new mask value; bit i = 1 enables line i.
- `int_req`, output, 1: interrupt request to the control FSM.
- `int_vector`, output, 16: handler address for the selected line.
- `int_code`, output, 3: index of the line being requested or serviced.
- `interrupt_reg`, output, 16: saved return PC.
- `pending`, output, 8: pending event bits.
- `in_service`, output, 1: a handler is active.

## Operation

- **Edge detect.** `hw_q` holds the previous sample of `hardware`. `rise = hardware & ~hw_q`. On every edge, `pending |= rise`. A long pulse counts once. A repeat event on a line that is already pending is absorbed, with no count.
- **Mask.** On `mask_we`, `mask <= mask_data`. Masking gates requests only; masked events still set `pending` and stay pending.
- **Priority.** The lowest index among `pending & mask` wins. `int_vector = VECTOR_BASE + int_code * VECTOR_STRIDE`, mod 2^16.
- **FSM states:** IDLE, REQ, SERVICE.
  - IDLE → REQ when `pending & mask` is nonzero. `int_code` is registered at this transition.
  - REQ: `int_req = 1`. `int_code` and `int_vector` are re-evaluated each cycle, so a higher-priority arrival preempts the choice before acknowledge.
  - REQ → IDLE if the selected line is masked off so that `pending & mask` becomes zero.
  - REQ → SERVICE on `int_ack`. Same edge: `interrupt_reg <= PC`, the selected pending bit is cleared, and `int_code` is frozen.
  - SERVICE: `in_service = 1`, `int_req = 0`. No nesting.
  - SERVICE → IDLE on `int_done`.
- **Ignored inputs:**
  - `int_ack` outside REQ.
  - `int_done` outside SERVICE.
- **Re-arm during service.** An event on the serviced line during SERVICE sets its pending bit again, and it is requested after return.
- **Same-edge collision.** An event arrives on the selected line on the same edge as `int_ack`: the clear wins and the event is lost. This is documented behaviour.

## Timing

- Reset values (asynchronous, immediate):
  - FSM = IDLE.
  - `pending`, `hw_q`, `int_code`, `int_req`, `in_service` = 0.
  - `mask` = 8'hFF.
  - `interrupt_reg` = 0.
  - `int_vector` = `VECTOR_BASE`.
- Reset asserted mid-service drops all of the above regardless of state.
- Latency without sync:
  - `hardware` high at edge n → pending bit set at edge n.
  - `int_req` high after edge n+1.
- `int_ack` sampled at edge m → `interrupt_reg` valid and `in_service` high after edge m. `int_req` low from the same edge.
- `int_done` at edge k → IDLE after k. If another event is pending, `int_req` rises after k+1.
- Mask written at edge n takes effect for the request decision at edge n+1.

## Configuration

- `INTC_SYNC_EN` defined: each `hardware` bit passes through a 2-flop synchronizer, reset to 0, before edge detect. Event-to-pending latency becomes 3 edges, and event-to-`int_req` becomes 4.
- `INTC_SYNC_EN` undefined: `hardware` feeds the edge detect directly with the latency above. Inputs must then be synchronous to `CLK`.

## Test plan

1. **Reset.** `RST_N` low mid-SERVICE → all outputs at reset values immediately; `mask` = FF.
2. **Single event.** `hardware = 8'b00000010` for 1 cycle, PC = 16'h0042 → `int_req` after 2 edges with `int_code = 1` and `int_vector = 16'h0110`. Then `int_ack` → `interrupt_reg = 16'h0042`, `pending = 0`. Then `int_done` → IDLE.
3. **Priority.** Line 4 is pending and in REQ; line 1 fires before `int_ack` → `int_code` switches to 1. After servicing line 1 and `int_done`, the line 4 request follows with `int_vector = 16'h0140`.
4. **Mask.** Write `mask = 8'hEF`, fire line 4 → `pending = 8'h10` and `int_req` stays 0. Write `mask = 8'hFF` → `int_req` rises on the next edge.
5. **Held pulse and re-arm.** Hold line 1 high for 20 cycles → exactly one pending set. Fire line 1 again during SERVICE → it is requested again after `int_done`.
6. **Stray handshake.** Pulse `int_ack` in IDLE and `int_done` in REQ → no state change and `interrupt_reg` unchanged.
